response_frame_tx: RTL and testbench

- Downstream stage of the serial receive/decode block.
- Consumes the received-frame strobe (dataInReady), decoded byte (dataIn), checksum verdict (checkSumBit) and the active mode/type.
- Builds an 18-bit reply frame, either a confirmation (ACK/NACK) or an answer byte, and shifts it out on dout at the same bit period the receiver samples at.
- Drives the SWIPT back-channel modulator.

---
 rtl/response_frame_tx_pkg.sv | 17 +
 rtl/response_frame_tx_if.sv | 21 ++
 rtl/response_frame_tx_frame_builder.sv | 21 ++
 rtl/response_frame_tx.sv | 81 ++++++++
 tb/tb_response_frame_tx.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/response_frame_tx_pkg.sv
// response_frame_tx_pkg: shared constants for the reply-frame transmitter
package response_frame_tx_pkg;
  localparam int FRAME_LEN = 18;
  localparam logic [7:0] ACK_DEFAULT = 8'hA5;
  localparam logic [7:0] NACK_DEFAULT = 8'h5A;
  localparam logic [1:0] MODE_QUERY = 2'b00;
  localparam logic [1:0] TYPE_Q1 = 2'b01;
  localparam logic [1:0] TYPE_Q2 = 2'b10;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] GAP = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] DONE = 3'd4;
  function automatic logic is_question(input logic [1:0] mode, input logic [1:0] ftype);
    return mode == MODE_QUERY && (ftype == TYPE_Q1 || ftype == TYPE_Q2);
  endfunction
endpackage

// File: rtl/response_frame_tx_if.sv
// response_frame_tx_if: receive-side inputs and serial reply outputs of the transmitter
// ports: swiptAlive/prog enable, dataInReady/dataIn/checkSumBit/mode/ftype/answerData in; dout/txBusy/txDone/overrun/lastRx out
interface response_frame_tx_if;
  logic swiptAlive;
  logic [1:0] prog;
  logic dataInReady;
  logic [7:0] dataIn;
  logic checkSumBit;
  logic [1:0] mode;
  logic [1:0] ftype;
  logic [7:0] answerData;
  logic dout;
  logic txBusy;
  logic txDone;
  logic overrun;
  logic [7:0] lastRx;
  modport master(output swiptAlive, prog, dataInReady, dataIn, checkSumBit, mode, ftype, answerData,
                 input dout, txBusy, txDone, overrun, lastRx);
  modport slave(input swiptAlive, prog, dataInReady, dataIn, checkSumBit, mode, ftype, answerData,
                output dout, txBusy, txDone, overrun, lastRx);
endinterface

// File: rtl/response_frame_tx_frame_builder.sv
// response_frame_tx_frame_builder: picks the reply payload and assembles the 18-bit frame
// ports: mode, ftype, checkSumBit, answerData in; payload, ones4, frame out
import response_frame_tx_pkg::*;
module response_frame_tx_frame_builder #(
  parameter logic [7:0] ACK_CODE = ACK_DEFAULT,
  parameter logic [7:0] NACK_CODE = NACK_DEFAULT
) (
  input  logic [1:0] mode,
  input  logic [1:0] ftype,
  input  logic       checkSumBit,
  input  logic [7:0] answerData,
  output logic [7:0] payload,
  output logic [3:0] ones4,
  output logic [FRAME_LEN-1:0] frame
);
  always_comb begin
    payload = is_question(mode, ftype) ? answerData : (checkSumBit ? ACK_CODE : NACK_CODE);
    ones4 = 4'($countones({mode, ftype, payload}));
    frame = {1'b1, mode, ftype, payload, ones4, 1'b0};
  end
endmodule

// File: rtl/response_frame_tx.sv
// response_frame_tx: captures a received-frame strobe and shifts out an ACK/NACK or answer frame
// ports: clk, nrst (async active-low), bus (slave side of response_frame_tx_if)
import response_frame_tx_pkg::*;
module response_frame_tx #(
  parameter int BIT_PERIOD = 200000,
  parameter int GAP_CYCLES = 400000,
  parameter logic [7:0] ACK_CODE = ACK_DEFAULT,
  parameter logic [7:0] NACK_CODE = NACK_DEFAULT
) (
  input logic clk,
  input logic nrst,
  response_frame_tx_if.slave bus
);
  localparam int BW = BIT_PERIOD > 1 ? $clog2(BIT_PERIOD) : 1;
  localparam int GW = GAP_CYCLES > 1 ? $clog2(GAP_CYCLES) : 1;
  logic [2:0] state;
  logic [BW-1:0] bcnt;
  logic [GW-1:0] gcnt;
  logic [4:0] bit_idx;
  logic [1:0] c_mode, c_type;
  logic c_csb;
  logic [7:0] c_ans;
  logic [FRAME_LEN-1:0] sr, frame;
  logic en;
  assign en = bus.swiptAlive & (bus.prog == 2'b11);
  response_frame_tx_frame_builder #(.ACK_CODE(ACK_CODE), .NACK_CODE(NACK_CODE)) u_fb (
    .mode(c_mode), .ftype(c_type), .checkSumBit(c_csb), .answerData(c_ans),
    .payload(), .ones4(), .frame(frame)
  );
  assign bus.dout = (state == SHIFT) & sr[FRAME_LEN-1];
  assign bus.txBusy = state == LOAD || state == GAP || state == SHIFT;
  assign bus.txDone = state == DONE;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      bcnt <= '0;
      gcnt <= '0;
      bit_idx <= '0;
      c_mode <= '0;
      c_type <= '0;
      c_csb <= 1'b0;
      c_ans <= '0;
      sr <= '0;
      bus.overrun <= 1'b0;
      bus.lastRx <= '0;
    end else if (!en) begin
      state <= IDLE;
    end else begin
      if (state != IDLE && bus.dataInReady) bus.overrun <= 1'b1;
      case (state)
        IDLE: if (bus.dataInReady) begin
          c_mode <= bus.mode;
          c_type <= bus.ftype;
          c_csb <= bus.checkSumBit;
          c_ans <= bus.answerData;
          bus.lastRx <= bus.dataIn;
          bus.overrun <= 1'b0;
          state <= LOAD;
        end
        LOAD: begin
          sr <= frame;
          gcnt <= GW'(GAP_CYCLES - 1);
          state <= GAP;
        end
        GAP: if (gcnt == '0) begin
          bcnt <= BW'(BIT_PERIOD - 1);
          bit_idx <= 5'(FRAME_LEN - 1);
          state <= SHIFT;
        end else gcnt <= gcnt - 1'b1;
        SHIFT: if (bcnt != '0) bcnt <= bcnt - 1'b1;
        else if (bit_idx == '0) state <= DONE;
        else begin
          bit_idx <= bit_idx - 1'b1;
          sr <= {sr[FRAME_LEN-2:0], 1'b0};
          bcnt <= BW'(BIT_PERIOD - 1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_response_frame_tx.sv
// tb_response_frame_tx: randomized self-checking bench against a frame/timeline reference model
module tb_response_frame_tx;
  localparam int BP = 4;
  localparam int GP = 2;
  localparam int KDONE = 2 + GP + 18 * BP;
  logic clk = 0;
  logic nrst;
  int checks = 0;
  int errors = 0;
  int inj_k = 0;
  int abort_k = 0;
  bit abort_kind = 0;
  logic dlog [0:99];
  logic blog [0:99];
  logic tlog [0:99];
  response_frame_tx_if bus();
  response_frame_tx #(.BIT_PERIOD(BP), .GAP_CYCLES(GP)) dut (.clk(clk), .nrst(nrst), .bus(bus));
  always #5 clk = ~clk;

  function automatic logic [17:0] model_frame(input logic [1:0] m, input logic [1:0] t, input logic c, input logic [7:0] a);
    logic [7:0] p;
    logic [11:0] body;
    int n;
    p = (m == 2'b00 && (t == 2'b01 || t == 2'b10)) ? a : (c ? 8'hA5 : 8'h5A);
    body = {m, t, p};
    n = 0;
    for (int i = 0; i < 12; i++) n += int'(body[i]);
    return {1'b1, body, n[3:0], 1'b0};
  endfunction

  // {dout, txBusy, txDone} expected k cycles after the accepting edge; ak>0 means enable dropped at k=ak
  function automatic logic [2:0] exp_out(input logic [17:0] f, input int k, input int ak);
    if (ak > 0 && k > ak) return 3'b000;
    if (k < 2 + GP) return 3'b010;
    if (k < KDONE) return {f[17 - (k - 2 - GP) / BP], 2'b10};
    if (k == KDONE) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic [17:0] captured();
    logic [17:0] r;
    for (int j = 0; j < 18; j++) r[17 - j] = dlog[2 + GP + BP * j + BP / 2];
    return r;
  endfunction

  task automatic strobe(input logic [1:0] m, input logic [1:0] t, input logic c, input logic [7:0] a, input logic [7:0] d);
    bus.mode = m;
    bus.ftype = t;
    bus.checkSumBit = c;
    bus.answerData = a;
    bus.dataIn = d;
    bus.dataInReady = 1;
  endtask

  task automatic record(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      dlog[k] = bus.dout;
      blog[k] = bus.txBusy;
      tlog[k] = bus.txDone;
      bus.dataInReady = (k == inj_k);
      if (k == inj_k) begin
        bus.mode = 2'($urandom);
        bus.ftype = 2'($urandom);
        bus.checkSumBit = 1'($urandom);
        bus.answerData = 8'($urandom);
        bus.dataIn = 8'($urandom);
      end
      if (abort_k > 0 && k == abort_k) begin
        if (abort_kind) bus.prog = 2'b10;
        else bus.swiptAlive = 0;
      end
      if (abort_k > 0 && k == abort_k + 1) begin
        bus.prog = 2'b11;
        bus.swiptAlive = 1;
      end
    end
    inj_k = 0;
    abort_k = 0;
  endtask

  task automatic test_reset();
    nrst = 0;
    #12;
    checks++;
    if ({bus.dout, bus.txBusy, bus.txDone, bus.overrun, bus.lastRx} !== 12'h0) begin
      errors++;
      $display("FAIL reset_values got %b expected 0", {bus.dout, bus.txBusy, bus.txDone, bus.overrun, bus.lastRx});
    end
    @(negedge clk);
    nrst = 1;
    strobe(2'b01, 2'b00, 1, 8'h00, 8'h11);
    inj_k = 5;
    record(20);
    checks++;
    if (bus.txBusy !== 1 || bus.overrun !== 1) begin
      errors++;
      $display("FAIL pre_reset_state busy=%b overrun=%b expected 1 1", bus.txBusy, bus.overrun);
    end
    #2 nrst = 0;
    #1;
    checks++;
    if (bus.dout !== 0 || bus.txBusy !== 0) begin
      errors++;
      $display("FAIL async_reset dout=%b busy=%b expected 0 0", bus.dout, bus.txBusy);
    end
    @(negedge clk);
    nrst = 1;
    @(negedge clk);
    checks++;
    if ({bus.txBusy, bus.txDone, bus.overrun, bus.dout} !== 4'b0) begin
      errors++;
      $display("FAIL after_reset got %b expected 0000", {bus.txBusy, bus.txDone, bus.overrun, bus.dout});
    end
  endtask

  task automatic test_answer();
    logic [17:0] f;
    logic [17:0] want;
    f = model_frame(2'b00, 2'b01, 0, 8'h3C);
    want = 18'b1_00_01_00111100_0101_0;
    strobe(2'b00, 2'b01, 0, 8'h3C, 8'hD7);
    record(KDONE + 2);
    for (int k = 1; k <= KDONE + 2; k++) begin
      checks++;
      if ({dlog[k], blog[k], tlog[k]} !== exp_out(f, k, 0)) begin
        errors++;
        $display("FAIL answer_timeline k=%0d got %b expected %b", k, {dlog[k], blog[k], tlog[k]}, exp_out(f, k, 0));
      end
    end
    checks++;
    if (captured() !== want) begin
      errors++;
      $display("FAIL answer_frame got %b expected %b", captured(), want);
    end
    checks++;
    if (bus.lastRx !== 8'hD7) begin
      errors++;
      $display("FAIL answer_lastRx got %h expected d7", bus.lastRx);
    end
  endtask

  task automatic test_ack();
    logic [17:0] want [2];
    want[0] = 18'b1_01_00_01011010_0101_0;
    want[1] = 18'b1_01_00_10100101_0101_0;
    for (int c = 1; c >= 0; c--) begin
      strobe(2'b01, 2'b00, 1'(c), 8'hFF, 8'h42);
      record(KDONE + 1);
      checks++;
      if (captured() !== want[c]) begin
        errors++;
        $display("FAIL ack_frame csb=%0d got %b expected %b", c, captured(), want[c]);
      end
      checks++;
      if (tlog[KDONE] !== 1 || tlog[KDONE - 1] !== 0 || tlog[KDONE + 1] !== 0) begin
        errors++;
        $display("FAIL ack_done_pulse csb=%0d got %b%b%b expected 010", c, tlog[KDONE - 1], tlog[KDONE], tlog[KDONE + 1]);
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] m, t;
    logic c;
    logic [7:0] a, d;
    logic [17:0] f;
    int bad;
    for (int i = 0; i < 10; i++) begin
      m = (i < 4) ? 2'b00 : 2'($urandom);
      t = 2'($urandom);
      c = 1'($urandom);
      a = 8'($urandom);
      d = 8'($urandom);
      f = model_frame(m, t, c, a);
      strobe(m, t, c, a, d);
      record(KDONE + 1);
      bad = 0;
      for (int k = 1; k <= KDONE + 1; k++) if ({dlog[k], blog[k], tlog[k]} !== exp_out(f, k, 0)) bad++;
      checks++;
      if (bad != 0 || captured() !== f) begin
        errors++;
        $display("FAIL random_frame i=%0d got %b expected %b bad_cycles=%0d", i, captured(), f, bad);
      end
      checks++;
      if (bus.lastRx !== d) begin
        errors++;
        $display("FAIL random_lastRx i=%0d got %h expected %h", i, bus.lastRx, d);
      end
    end
  endtask

  task automatic test_overrun();
    logic [17:0] f;
    int bad;
    f = model_frame(2'b10, 2'b11, 0, 8'h00);
    strobe(2'b10, 2'b11, 0, 8'h00, 8'h01);
    inj_k = 40;
    record(KDONE + 6);
    bad = 0;
    for (int k = 1; k <= KDONE + 6; k++) if ({dlog[k], blog[k], tlog[k]} !== exp_out(f, k, 0)) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL overrun_frame got %b expected %b bad_cycles=%0d", captured(), f, bad);
    end
    checks++;
    if (bus.overrun !== 1 || bus.lastRx !== 8'h01) begin
      errors++;
      $display("FAIL overrun_set overrun=%b lastRx=%h expected 1 01", bus.overrun, bus.lastRx);
    end
    strobe(2'b11, 2'b01, 1, 8'h00, 8'h02);
    record(1);
    checks++;
    if (bus.overrun !== 0 || bus.lastRx !== 8'h02) begin
      errors++;
      $display("FAIL overrun_clear overrun=%b lastRx=%h expected 0 02", bus.overrun, bus.lastRx);
    end
    record(KDONE);
  endtask

  task automatic test_abort();
    logic [17:0] f;
    int bad;
    int dones;
    for (int kind = 0; kind < 2; kind++) begin
      f = model_frame(2'b01, 2'b10, 1, 8'h00);
      strobe(2'b01, 2'b10, 1, 8'h00, 8'h33);
      abort_kind = 1'(kind);
      abort_k = kind ? 30 : 2;
      record(KDONE + 2);
      bad = 0;
      dones = 0;
      for (int k = 1; k <= KDONE + 2; k++) begin
        if ({dlog[k], blog[k], tlog[k]} !== exp_out(f, k, kind ? 30 : 2)) bad++;
        dones += int'(tlog[k]);
      end
      checks++;
      if (bad != 0 || dones != 0) begin
        errors++;
        $display("FAIL abort kind=%0d bad_cycles=%0d done_pulses=%0d expected 0 0", kind, bad, dones);
      end
      f = model_frame(2'b00, 2'b10, 0, 8'hC3);
      strobe(2'b00, 2'b10, 0, 8'hC3, 8'h44);
      record(KDONE + 1);
      bad = 0;
      for (int k = 1; k <= KDONE + 1; k++) if ({dlog[k], blog[k], tlog[k]} !== exp_out(f, k, 0)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL abort_resend kind=%0d got %b expected %b bad_cycles=%0d", kind, captured(), f, bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] f;
    int bad;
    strobe(2'b01, 2'b01, 1, 8'h00, 8'h55);
    inj_k = KDONE;
    record(KDONE + 1);
    checks++;
    if (tlog[KDONE] !== 1 || bus.overrun !== 1 || blog[KDONE + 1] !== 0) begin
      errors++;
      $display("FAIL b2b_done_strobe done=%b overrun=%b busy=%b expected 1 1 0", tlog[KDONE], bus.overrun, blog[KDONE + 1]);
    end
    f = model_frame(2'b00, 2'b01, 1, 8'h96);
    strobe(2'b00, 2'b01, 1, 8'h96, 8'h66);
    record(KDONE + 1);
    bad = 0;
    for (int k = 1; k <= KDONE + 1; k++) if ({dlog[k], blog[k], tlog[k]} !== exp_out(f, k, 0)) bad++;
    checks++;
    if (bad != 0 || bus.overrun !== 0 || bus.lastRx !== 8'h66) begin
      errors++;
      $display("FAIL b2b_accept got %b expected %b bad_cycles=%0d overrun=%b lastRx=%h", captured(), f, bad, bus.overrun, bus.lastRx);
    end
  endtask

  initial begin
    bus.swiptAlive = 1;
    bus.prog = 2'b11;
    bus.dataInReady = 0;
    bus.dataIn = 0;
    bus.checkSumBit = 0;
    bus.mode = 0;
    bus.ftype = 0;
    bus.answerData = 0;
    test_reset();
    test_answer();
    test_ack();
    test_random();
    test_overrun();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
